ctrl_pipe: RTL
==============

// Module: ctrl_pipe
// PURPOSE
//  Consumer end of the decode-stage control bus: takes the D-stage control word from the main/ALU
//  decoders and carries it through the E/M/W pipeline registers with bubble insertion.
//  Resolves the branch/jump redirect (PCSrcE) in Execute and keeps a retired-instruction counter.
//  Sits between the controller and the datapath/hazard unit of the 5-stage RV32I pipeline.
// PARAMETERS
//  CNT_W   32  width of retired-instruction counter (wraps modulo 2**CNT_W)
// PORTS
//  clk          in   1   pipeline clock (single clock domain)
//  reset        in   1   synchronous, active-high reset
//  RegWriteD    in   1   D-stage register-file write enable
//  ResultSrcD   in   2   D-stage writeback select (00 ALU, 01 mem, 10 PC+4)
//  MemWriteD    in   1   D-stage store enable
//  JumpD        in   1   D-stage jal
//  BranchD      in   1   D-stage conditional branch
//  ALUControlD  in   3   D-stage ALU op
//  ALUSrcD      in   1   D-stage ALU B-operand select (1 = immediate)
//  funct3D      in   3   D-stage funct3; bit0 selects beq(0)/bne(1)
//  Rs1D,Rs2D,RdD in  5   D-stage register addresses
//  ValidD       in   1   D-stage holds a real instruction
//  FlushE       in   1   hazard unit: turn the E-register load into a bubble
//  ZeroE        in   1   ALU zero flag for the E-stage instruction
//  ALUControlE  out  3   E-stage ALU op
//  ALUSrcE      out  1   E-stage ALU B select
//  ResultSrcE0  out  1   ResultSrcE[0] (load-in-E, for hazard unit)
//  Rs1E,Rs2E,RdE out 5   E-stage register addresses
//  PCSrcE       out  1   redirect fetch to branch/jump target
//  RegWriteM    out  1   M-stage write enable (forwarding)
//  MemWriteM    out  1   M-stage store enable
//  ResultSrcM   out  2   M-stage writeback select
//  RdM          out  5   M-stage destination
//  RegWriteW    out  1   W-stage register-file write enable
//  ResultSrcW   out  2   W-stage writeback select
//  RdW          out  5   W-stage destination
//  RetiredCnt   out  CNT_W  count of valid instructions that left W
// BEHAVIOUR
//  - Reset: every E/M/W register clears to 0 on the first rising clk with reset=1 (all outputs 0,
//    all stage valid bits 0, RetiredCnt=0). reset beats FlushE and every data input.
//  - Latency: D->E, E->M, M->W each exactly one cycle; no stall input (E/M/W always advance).
//  - FlushE=1: E register loads the bubble value (all controls 0, addresses 0, ValidE=0) instead
//    of D values; M/W advance normally. FlushE and reset together -> reset result (identical).
//  - ValidD=0 is loaded as a bubble, same as FlushE.
//  - PCSrcE (combinational from E regs + ZeroE) = ValidE & (JumpE | BranchE & (ZeroE ^ funct3E[0])).
//    funct3E values other than 000/001 with BranchE=1 are treated per bit0 only.
//  - M/W stages register only the fields listed; MemWriteM, RegWriteM/W are forced 0 if the
//    stage valid bit is 0 (bubbles never write).
//  - RetiredCnt increments by 1 on each clk where ValidW=1 and reset=0; wraps all-ones -> 0.
//  - No state machine beyond the stage registers; no X may reach any output after reset.
// STRUCTURE
//  - Shared package ctrl_pkg: ResultSrc encodings (RES_ALU, RES_MEM, RES_PC4), ALU op codes,
//    funct3 branch codes, packed structs ctrl_e_t / ctrl_m_t / ctrl_w_t with BUBBLE constants.
//  - One sub-module: ctrl_stage_reg #(type T) - sync-reset, sync-clear register loading T;
//    instantiated three times (E with clear=FlushE|~ValidD, M and W with clear=0).
// TESTING
//  1 reset held 2 cycles, inputs random -> all outputs 0, RetiredCnt=0 on cycle after release.
//  2 add x3 (RegWriteD=1,ResultSrcD=00,RdD=3,ValidD=1) -> RdE=3 @+1, RegWriteM=1,RdM=3 @+2,
//    RegWriteW=1,RdW=3 @+3, RetiredCnt=1 @+4.
//  3 beq in E with ZeroE=1 -> PCSrcE=1; ZeroE=0 -> 0; bne (funct3=001) ZeroE=0 -> PCSrcE=1.
//  4 jal (JumpD=1,ResultSrcD=10) with FlushE=1 same cycle -> E bubble, PCSrcE=0, nothing
//    retires, RegWriteW stays 0.
//  5 sw (MemWriteD=1,RegWriteD=0) -> MemWriteM=1 for exactly one cycle, RegWriteW=0.
//  6 CNT_W=4, 17 back-to-back valid instrs -> RetiredCnt wraps 15->0->1; reset mid-stream -> 0.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared control-bus definitions for the E/M/W control pipeline of the RV32I core.
package ctrl_pkg;

  localparam int unsigned REG_W = 5;
  localparam int unsigned RES_W = 2;
  localparam int unsigned ALU_W = 3;
  localparam int unsigned F3_W  = 3;

  localparam logic [RES_W-1:0] RES_ALU = 2'b00;
  localparam logic [RES_W-1:0] RES_MEM = 2'b01;
  localparam logic [RES_W-1:0] RES_PC4 = 2'b10;

  localparam logic [ALU_W-1:0] ALU_ADD = 3'b000;
  localparam logic [ALU_W-1:0] ALU_SUB = 3'b001;
  localparam logic [ALU_W-1:0] ALU_AND = 3'b010;
  localparam logic [ALU_W-1:0] ALU_OR  = 3'b011;
  localparam logic [ALU_W-1:0] ALU_SLT = 3'b101;

  localparam logic [F3_W-1:0] F3_BEQ = 3'b000;
  localparam logic [F3_W-1:0] F3_BNE = 3'b001;

  // Only funct3[0] matters downstream of decode, so E keeps just that bit (br_inv).
  typedef struct packed {
    logic             valid;
    logic             reg_write;
    logic [RES_W-1:0] result_src;
    logic             mem_write;
    logic             jump;
    logic             branch;
    logic [ALU_W-1:0] alu_control;
    logic             alu_src;
    logic             br_inv;
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
    logic [REG_W-1:0] rd;
  } ctrl_e_t;

  typedef struct packed {
    logic             valid;
    logic             reg_write;
    logic [RES_W-1:0] result_src;
    logic             mem_write;
    logic [REG_W-1:0] rd;
  } ctrl_m_t;

  typedef struct packed {
    logic             valid;
    logic             reg_write;
    logic [RES_W-1:0] result_src;
    logic [REG_W-1:0] rd;
  } ctrl_w_t;

  localparam ctrl_e_t BUBBLE_E = '0;
  localparam ctrl_m_t BUBBLE_M = '0;
  localparam ctrl_w_t BUBBLE_W = '0;

  // Redirect decision for the instruction held in Execute.
  function automatic logic redirect(input ctrl_e_t e, input logic zero);
    return e.valid & (e.jump | (e.branch & (zero ^ e.br_inv)));
  endfunction

endpackage

// File: rtl/ctrl_stage_reg.sv
// Generic pipeline register with synchronous reset and synchronous clear-to-bubble.
module ctrl_stage_reg #(
  parameter type T = logic
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  T     d,
  output T     q
);

  // Bubble encoding is all-zero for every stage struct.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      q <= '0;
    end else begin
      q <= d;
    end
  end

endmodule

// File: rtl/ctrl_pipe.sv
// Carries the decoded control word through E/M/W, resolves the redirect in Execute
// and counts retired instructions.
module ctrl_pipe
  import ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             RegWriteD,
  input  logic [RES_W-1:0] ResultSrcD,
  input  logic             MemWriteD,
  input  logic             JumpD,
  input  logic             BranchD,
  input  logic [ALU_W-1:0] ALUControlD,
  input  logic             ALUSrcD,
  input  logic [F3_W-1:0]  funct3D,
  input  logic [REG_W-1:0] Rs1D,
  input  logic [REG_W-1:0] Rs2D,
  input  logic [REG_W-1:0] RdD,
  input  logic             ValidD,
  input  logic             FlushE,
  input  logic             ZeroE,
  output logic [ALU_W-1:0] ALUControlE,
  output logic             ALUSrcE,
  output logic             ResultSrcE0,
  output logic [REG_W-1:0] Rs1E,
  output logic [REG_W-1:0] Rs2E,
  output logic [REG_W-1:0] RdE,
  output logic             PCSrcE,
  output logic             RegWriteM,
  output logic             MemWriteM,
  output logic [RES_W-1:0] ResultSrcM,
  output logic [REG_W-1:0] RdM,
  output logic             RegWriteW,
  output logic [RES_W-1:0] ResultSrcW,
  output logic [REG_W-1:0] RdW,
  output logic [CNT_W-1:0] RetiredCnt
);

  ctrl_e_t e_d, e_q;
  ctrl_m_t m_d, m_q;
  ctrl_w_t w_d, w_q;
  logic    clear_e;
  logic    unused_f3;

  // funct3[2:1] do not affect branch polarity.
  assign unused_f3 = ^funct3D[2:1];

  // Decode-side word; an invalid slot is squashed exactly like a flush.
  always_comb begin
    e_d             = BUBBLE_E;
    e_d.valid       = ValidD;
    e_d.reg_write   = RegWriteD;
    e_d.result_src  = ResultSrcD;
    e_d.mem_write   = MemWriteD;
    e_d.jump        = JumpD;
    e_d.branch      = BranchD;
    e_d.alu_control = ALUControlD;
    e_d.alu_src     = ALUSrcD;
    e_d.br_inv      = funct3D[0];
    e_d.rs1         = Rs1D;
    e_d.rs2         = Rs2D;
    e_d.rd          = RdD;
  end

  assign clear_e = FlushE | ~ValidD;

  // Write enables are gated by the stage valid bit so bubbles never write.
  always_comb begin
    m_d            = BUBBLE_M;
    m_d.valid      = e_q.valid;
    m_d.reg_write  = e_q.valid & e_q.reg_write;
    m_d.result_src = e_q.result_src;
    m_d.mem_write  = e_q.valid & e_q.mem_write;
    m_d.rd         = e_q.rd;
  end

  always_comb begin
    w_d            = BUBBLE_W;
    w_d.valid      = m_q.valid;
    w_d.reg_write  = m_q.valid & m_q.reg_write;
    w_d.result_src = m_q.result_src;
    w_d.rd         = m_q.rd;
  end

  ctrl_stage_reg #(.T(ctrl_e_t)) u_reg_e (
    .clk   (clk),
    .reset (reset),
    .clear (clear_e),
    .d     (e_d),
    .q     (e_q)
  );

  ctrl_stage_reg #(.T(ctrl_m_t)) u_reg_m (
    .clk   (clk),
    .reset (reset),
    .clear (1'b0),
    .d     (m_d),
    .q     (m_q)
  );

  ctrl_stage_reg #(.T(ctrl_w_t)) u_reg_w (
    .clk   (clk),
    .reset (reset),
    .clear (1'b0),
    .d     (w_d),
    .q     (w_q)
  );

  // Counts every valid instruction leaving W; wraps modulo 2**CNT_W.
  always_ff @(posedge clk) begin
    if (reset) begin
      RetiredCnt <= '0;
    end else if (w_q.valid) begin
      RetiredCnt <= RetiredCnt + CNT_W'(1);
    end
  end

  assign ALUControlE = e_q.alu_control;
  assign ALUSrcE     = e_q.alu_src;
  assign ResultSrcE0 = e_q.result_src[0];
  assign Rs1E        = e_q.rs1;
  assign Rs2E        = e_q.rs2;
  assign RdE         = e_q.rd;
  assign PCSrcE      = redirect(e_q, ZeroE);

  assign RegWriteM   = m_q.reg_write;
  assign MemWriteM   = m_q.mem_write;
  assign ResultSrcM  = m_q.result_src;
  assign RdM         = m_q.rd;

  assign RegWriteW   = w_q.reg_write;
  assign ResultSrcW  = w_q.result_src;
  assign RdW         = w_q.rd;

endmodule
